reg_file_we_par: RTL

Parametrised register file: DEPTH words of WIDTH bits with an active-low write enable, active-low byte-lane enables, and a registered active-low read port. It replaces single fixed-width write-enable registers in the datapath wherever several addressable words are needed. It also detects out-of-range accesses and reports them through a sticky error flag.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_word_be.sv | 38 +++
 rtl/reg_file_we_par.sv | 115 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the byte-enabled register file: default geometry,
// the storage word type and the lane-enable to bit-mask expansion.
package reg_file_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef logic [DEF_WIDTH-1:0] word_t;

    // One active-low lane enable expands to the eight data bits it governs.
    function automatic logic [7:0] be_lane_mask(input logic lane_en_n);
        return lane_en_n ? 8'h00 : 8'hFF;
    endfunction

endpackage

// File: rtl/reg_word_be.sv
// One storage word with per-byte-lane active-low load enables,
// asynchronously reset to RESET_VAL.
module reg_word_be
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH/8-1:0] lane_en_n,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   word_o
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    for (genvar k = 0; k < WIDTH / 8; k++) begin : g_lane
        assign mask[8*k +: 8] = be_lane_mask(lane_en_n[k]);
    end

    always_comb begin
        word_d = (data_in & mask) | (word_q & ~mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= RESET_VAL;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/reg_file_we_par.sv
// DEPTH x WIDTH register file with active-low write/byte/read enables, a
// registered read port and a sticky out-of-range error flag.
// Build option: define REG_FILE_BYPASS_EN to forward same-address write data
// into a simultaneous read; otherwise such a read returns the old word.
module reg_file_we_par
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_n,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH/8-1:0]       be_n,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     re_n,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             NB      = WIDTH / 8;
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_ok;
    logic             oor_access;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
    assign wr_ok       = !we_n && wr_in_range;
    assign oor_access  = (!we_n && !wr_in_range) || (!re_n && !rd_in_range);

    for (genvar k = 0; k < NB; k++) begin : g_wmask
        assign wmask[8*k +: 8] = be_lane_mask(be_n[k]);
    end

    // Only the addressed word sees the caller's lane enables; all others are masked off.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [NB-1:0] lane_en_n;
        assign lane_en_n = be_n | {NB{!(wr_ok && (wr_addr == AW'(i)))}};

        reg_word_be #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_word (
            .clk       (clk),
            .rst_n     (rst_n),
            .lane_en_n (lane_en_n),
            .data_in   (data_in),
            .word_o    (words[i])
        );
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = words[rd_addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr)) begin
                rd_word = (data_in & wmask) | (rd_word & ~wmask);
            end
`endif
        end
    end

    always_comb begin
        data_out_d = re_n ? data_out_q : rd_word;
        rd_valid_d = !re_n;
        // A fresh out-of-range access outranks a clear request in the same cycle.
        if (oor_access) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

`ifndef REG_FILE_BYPASS_EN
    // wmask only feeds the read path when forwarding is built in.
    logic unused_wmask;
    assign unused_wmask = ^wmask;
`endif

endmodule
